// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// No logic: enums, MMIO offsets and an alignment helper.
// No flow control of its own; users handle req/ready.
package dmem_pkg;

  // Access width as encoded on the CPU's size field; 2'd3 is left out on purpose.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Controller sequencing: accept, count wait states, present completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte offsets inside the memory-mapped I/O window.
  localparam int unsigned IO_OUT_OFF = 0;
  localparam int unsigned CYC_OFF    = 4;
  localparam int unsigned MMIO_SPAN  = 256;

  // Natural alignment for the given access width; the illegal size never aligns.
  function automatic logic access_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      SZ_WORD: return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: merges sub-word stores into a word, extracts/extends loads.
// Purely combinational, zero cycles.
// No flow control; the controller decides when results are used.
module dmem_lane import dmem_pkg::*; (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane pick: byte lane off, half lane off[1].
  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = word[{off[1], 4'b0000} +: 16];

  // Store merge: only the addressed lanes change, the rest of the word is kept.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{off, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: merged = wdata;
      default: merged = word;
    endcase
  end

  // Load extract: right-justify the lane, then sign- or zero-extend; word ignores uns.
  always_comb begin
    extracted = word;
    case (size)
      SZ_BYTE: extracted = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: extracted = {{16{~uns & half_sel[15]}}, half_sel};
      SZ_WORD: extracted = word;
      default: extracted = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller: word RAM with byte/half/word access plus an MMIO window.
// Legal access completes LATENCY+2 cycles after req, a rejected one after 1 cycle.
// CPU holds req until the one-cycle ready pulse; dropping req during WAIT aborts.
module dmem_ctrl import dmem_pkg::*; #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              fault,
  output logic [DATA_W-1:0] io_out
);

  localparam int                IDX_W  = $clog2(DEPTH);
  localparam logic [2:0]        LAT    = 3'(LATENCY);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(MMIO_BASE);

  state_t            state, state_n;
  logic [2:0]        cnt;
  logic              fault_q;
  logic [31:0]       cyc;
  logic              do_access;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_word, ram_merged, ram_load, io_rd, load_val;

  logic [ADDR_W-1:0] word_addr, io_off;
  logic [IDX_W-1:0]  widx;
  logic              in_ram, in_io, legal;

  // Address decode. RAM wins should the window ever overlap it.
  assign word_addr = addr >> 2;
  assign widx      = word_addr[IDX_W-1:0];
  assign in_ram    = word_addr < ADDR_W'(DEPTH);
  assign io_off    = addr - BASE_A;
  assign in_io     = !in_ram && (addr >= BASE_A) && (io_off < ADDR_W'(MMIO_SPAN));
  // MMIO registers are word-only; sub-word access there is rejected like a misalignment.
  assign legal     = access_aligned(size, addr[1:0]) &&
                     (in_ram || (in_io && size == SZ_WORD));

  assign ram_word = mem[widx];

  dmem_lane u_lane (
    .size      (size),
    .off       (addr[1:0]),
    .uns       (uns),
    .word      (ram_word),
    .wdata     (wdata),
    .merged    (ram_merged),
    .extracted (ram_load)
  );

  // MMIO read mux: output register, cycle counter, everything else reads zero.
  always_comb begin
    io_rd = '0;
    if (io_off == ADDR_W'(IO_OUT_OFF)) io_rd = io_out;
    else if (io_off == ADDR_W'(CYC_OFF)) io_rd = cyc;
  end

  assign load_val = in_ram ? ram_load : io_rd;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state: accept or reject in IDLE, count down in WAIT, single DONE cycle.
  always_comb begin
    state_n   = state;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_n = legal ? WAIT : DONE;
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
        end else if (cnt == 3'd0) begin
          do_access = 1'b1;
          state_n   = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ready = (state == DONE);
  assign fault = ready & fault_q;

  // Wait counter, fault flag, load result, MMIO output register and cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 3'd0;
      fault_q <= 1'b0;
      rdata   <= '0;
      io_out  <= '0;
      cyc     <= 32'd0;
    end else begin
      cyc <= cyc + 32'd1;
      if (state == IDLE && req) begin
        cnt     <= LAT;
        fault_q <= ~legal;
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (do_access) begin
        if (!we)
          rdata <= load_val;
        else if (in_io && io_off == ADDR_W'(IO_OUT_OFF))
          io_out <= wdata;
      end
    end
  end

  // RAM write port: read-modify-write of the addressed word; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_access && we && in_ram) mem[widx] <= ram_merged;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl against a byte-array reference model.
// Drives one access at a time and measures req-to-ready cycles.
// Holds req until ready, then releases it for at least one cycle.
module tb_dmem_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, io_out;
  logic        ready, fault;

  logic        req0, we0, uns0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0, rdata0, io_out0;
  logic        ready0, fault0;

  dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(2), .MMIO_BASE(BASE)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .fault(fault), .io_out(io_out)
  );

  dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(0), .MMIO_BASE(BASE)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .size(size0), .uns(uns0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0), .fault(fault0), .io_out(io_out0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Clock edges since reset release; the counter register read at an edge equals edges-1 just after it.
  int unsigned edges;
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  // Reference state: RAM as little-endian bytes, the I/O register, the last load result.
  logic [7:0]  mbytes [256];
  logic [31:0] m_io, m_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a % 2 != 0) return 1'b1;
    if (sz == 2'd2 && a % 4 != 0) return 1'b1;
    if (a < 256) return 1'b0;
    if (a >= BASE && a - BASE < 256) return sz != 2'd2;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_ram_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    int          n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mbytes[a + i]) << (8 * i));
    if (!u && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // One access on the LATENCY=2 instance; starts just after an edge, ends just after an edge.
  task automatic acc(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input string tag, output logic [31:0] got);
    logic        ef;
    logic [31:0] off;
    int          n;
    ef = model_fault(sz, a);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
    end
    if (!ready) n = 99;
    chk({tag, " latency"}, 32'(n), ef ? 32'd1 : 32'd4);
    chk({tag, " fault"}, {31'd0, fault}, {31'd0, ef});
    if (!ef) begin
      if (!w) begin
        if (a < 256) begin
          m_rdata = model_ram_load(sz, u, a);
        end else begin
          off = a - BASE;
          m_rdata = (off == 0) ? m_io : (off == 4) ? 32'(edges - 1) : 32'd0;
        end
      end else if (a < 256) begin
        for (int i = 0; i < (1 << sz); i++) mbytes[a + i] = wd[8 * i +: 8];
      end else if (a == BASE) begin
        m_io = wd;
      end
    end
    chk({tag, " rdata"}, rdata, m_rdata);
    chk({tag, " io_out"}, io_out, m_io);
    got = rdata;
    req = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ready pulse width"}, {31'd0, ready}, 32'd0);
  endtask

  // Word access on the LATENCY=0 instance, reporting req-to-ready cycles.
  task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] got);
    req0 = 1'b1; we0 = w; size0 = 2'd2; uns0 = 1'b0; addr0 = a; wdata0 = wd;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ready0) break;
    end
    if (!ready0) lat = 99;
    got = rdata0;
    req0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] got, c1, c2;
    logic [31:0] ra;
    logic [1:0]  rs;
    logic        rw, ru;
    int          seen, lat0;

    req = 0; we = 0; size = 0; uns = 0; addr = 0; wdata = 0;
    req0 = 0; we0 = 0; size0 = 0; uns0 = 0; addr0 = 0; wdata0 = 0;
    m_io = 0; m_rdata = 0;
    reset = 1'b1;
    #1;
    chk("reset rdata", rdata, 32'd0);
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset fault", {31'd0, fault}, 32'd0);
    chk("reset io_out", io_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Give every RAM word a known value so the model never holds unknowns.
    for (int i = 0; i < 64; i++) acc(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "init", got);

    // Word store then load.
    acc(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st word", got);
    acc(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld word", got);
    chk("ld word literal", got, 32'hDEADBEEF);

    // Byte merge and extension.
    acc(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "st base", got);
    acc(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, "st byte", got);
    acc(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld merged", got);
    chk("merged literal", got, 32'h80223344);
    acc(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "ld sbyte", got);
    chk("sbyte literal", got, 32'hFFFFFF80);
    acc(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "ld ubyte", got);
    chk("ubyte literal", got, 32'h00000080);
    acc(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "ld shalf", got);

    // Alignment, size and range rejections leave memory and rdata alone.
    acc(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, "half misaligned", got);
    acc(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFFFFFF, "word misaligned", got);
    acc(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "size3", got);
    acc(1'b1, 2'd2, 1'b0, 32'h100, 32'h55, "out of range", got);
    acc(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld after faults", got);

    // MMIO window.
    acc(1'b1, 2'd2, 1'b0, BASE, 32'hA5, "io store", got);
    acc(1'b0, 2'd2, 1'b0, BASE, 32'h0, "io load", got);
    acc(1'b0, 2'd2, 1'b0, BASE + 4, 32'h0, "cyc read1", c1);
    repeat (5) begin @(posedge clk); #1; end
    acc(1'b0, 2'd2, 1'b0, BASE + 4, 32'h0, "cyc read2", c2);
    chk("cyc diff", c2 - c1, 32'd10);
    acc(1'b1, 2'd2, 1'b0, BASE + 4, 32'h1, "cyc write ignored", got);
    acc(1'b1, 2'd2, 1'b0, BASE + 8, 32'h7, "io spare write", got);
    acc(1'b0, 2'd2, 1'b0, BASE + 8, 32'h0, "io spare read", got);
    acc(1'b0, 2'd0, 1'b0, BASE, 32'h0, "io byte", got);

    // Abort: drop req during WAIT.
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h20; wdata = 32'h12345678;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (ready) seen++; end
    req = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (ready) seen++; end
    chk("abort ready", 32'(seen), 32'd0);
    acc(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "ld after abort", got);

    // Random traffic, mostly RAM, some misaligned, illegal-size and out-of-range.
    for (int i = 0; i < 60; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 320));
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      acc(rw, rs, ru, ra, $urandom, "rand", got);
    end

    // Asynchronous reset in the middle of a store's wait.
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h30;
    wdata = ~model_ram_load(2'd2, 1'b0, 32'h30);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async rdata", rdata, 32'd0);
    chk("async ready", {31'd0, ready}, 32'd0);
    chk("async fault", {31'd0, fault}, 32'd0);
    chk("async io_out", io_out, 32'd0);
    req = 1'b0;
    m_rdata = 0; m_io = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    acc(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "ld after reset", got);

    // Zero wait states.
    acc0(1'b1, 32'h8, 32'h5A5A1234, lat0, got);
    chk("lat0 store latency", 32'(lat0), 32'd2);
    acc0(1'b0, 32'h8, 32'h0, lat0, got);
    chk("lat0 load latency", 32'(lat0), 32'd2);
    chk("lat0 load data", got, 32'h5A5A1234);
    chk("lat0 fault", {31'd0, fault0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory.
- Sits between the CPU's load/store port and a word-organised RAM array. Adds configurable wait states, byte/half/word accesses with sign or zero extension, and alignment/range faults.
- Adds a small memory-mapped I/O window: an output register and a free-running cycle counter.
- The CPU stalls on `ready`.

Parameters:
- DATA_W, 32, data width in bits (fixed at 32; byte-lane logic assumes 4 lanes)
- ADDR_W, 32, byte-address width
- DEPTH, 64, RAM depth in words (power of two, 4..4096)
- LATENCY, 2, wait cycles before an access completes (0..7)
- MMIO_BASE, 32'hFFFF_0000, base byte address of the I/O window

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  access request; held stable with all request fields until ready
- we  input  1  1 = store, 0 = load
- size  input  2  0 byte, 1 half, 2 word; 3 is illegal and faults
- uns  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- addr  input  ADDR_W  byte address
- wdata  input  DATA_W  store data, right-justified
- rdata  output  DATA_W  load result, valid while ready=1
- ready  output  1  one-cycle completion pulse
- fault  output  1  qualified by ready; access rejected, no side effects
- io_out  output  DATA_W  MMIO output register

Behaviour:
- Reset (async, any state):
  - state=IDLE; rdata=0, ready=0, fault=0, io_out=0, cycle counter=0.
  - A pending store is dropped.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On req=1, decode the request.
  - Illegal if: size=3; half with addr[0]≠0; word with addr[1:0]≠0; or address outside both the RAM (word index ≥ DEPTH) and the MMIO window.
  - Illegal -> DONE with fault=1, no write.
  - Legal -> load wait counter with LATENCY, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - The access is performed on the edge where the counter is 0: store commits, load data is registered into rdata. Then -> DONE.
  - LATENCY=0: access is performed on the first WAIT edge.
  - Latency req->ready = LATENCY+2 cycles; fault latency = 1 cycle.
- DONE:
  - ready=1 for exactly one cycle, then -> IDLE.
  - A back-to-back req is accepted in the following IDLE cycle.
  - Minimum 1 idle cycle between accesses.
- req deasserted while in WAIT: abort, -> IDLE, no write, no ready.
- Byte order is little-endian.
  - Store byte/half: merge into lane addr[1:0]/addr[1]; other bytes are unchanged (read-modify-write on the word).
  - Load: extract the lane, then extend per uns. Word ignores uns.
- MMIO, word accesses only; sub-word MMIO access faults:
  - MMIO_BASE+0: R/W io_out.
  - MMIO_BASE+4: R cycle counter; writes ignored without fault.
  - Other offsets in the 256-byte window: read 0, write ignored.
- Cycle counter: 32-bit, increments every clock, wraps 0xFFFFFFFF->0.
- rdata holds its last value except when a load completes. On a store or fault, rdata is unchanged.

Decomposition:
- Package `dmem_pkg`:
  - `size_t` enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - `state_t` enum (IDLE, WAIT, DONE).
  - MMIO offset constants (IO_OUT_OFF=0, CYC_OFF=4, MMIO_SPAN=256).
- One combinational sub-module, `dmem_lane`:
  - store merge: old word + wdata + size + addr[1:0] -> new word.
  - load extract: word + size + addr[1:0] + uns -> rdata.
- The RAM array, FSM and MMIO stay in `dmem_ctrl`.

Test Plan:
- LATENCY=2: word store 0xDEADBEEF @0x10, then word load @0x10 -> each ready exactly 4 cycles after req; rdata=0xDEADBEEF; fault=0.
- Byte store 0x80 @0x13 over 0x11223344, then:
  - word load @0x10 -> 0x80223344.
  - signed byte load @0x13 -> 0xFFFFFF80.
  - uns byte load -> 0x00000080.
- Alignment and range faults, each -> ready+fault one cycle after req, memory unchanged:
  - half load @0x11.
  - word store @0x12.
  - size=3.
  - word @ DEPTH*4 (0x100).
- MMIO:
  - word store 0xA5 @MMIO_BASE -> io_out=0x000000A5 at ready.
  - two cycle-counter reads 10 cycles apart -> difference 10.
  - byte load @MMIO_BASE -> fault.
- Store of 0x12345678 @0x20 with req dropped during WAIT; later word load @0x20 -> old value; no ready pulse during the abort.
- Reset asserted mid-WAIT of a store -> outputs 0 immediately (async), io_out=0; subsequent load of that address shows the old contents. Repeat the latency check with LATENCY=0 -> ready 2 cycles after req.
